int_alu_issue_ctrl: RTL and testbench
=====================================

// Module: int_alu_issue_ctrl
// PURPOSE
//  Sequences the combinational int_alu for the execute stage. Accepts one op per
//  handshake, holds operands on the ALU for 1 cycle (MUL_LAT cycles for MUL) and
//  registers the result. Presents it to writeback with valid/ready backpressure.
//  Stalls upstream while busy; a flush kills any op in flight.
// PARAMETERS
//  MUL_LAT   3   cycles operands are held on the ALU for MUL; legal range 1..16
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rsn_i          in   1   reset, asynchronous, active-low
//  req_valid_i    in   1   upstream op valid
//  req_ready_o    out  1   controller can accept op this cycle
//  req_instr_i    in   32  instruction word
//  req_pc_i       in   32  PC of instruction
//  req_a_i        in   32  operand A (rs1)
//  req_b_i        in   32  operand B (rs2)
//  req_rd_i       in   5   destination register
//  kill_i         in   1   flush: drop op in flight and pending result
//  alu_instr_o    out  32  to int_alu instr_i
//  alu_pc_o       out  32  to int_alu pc_i
//  alu_a_o        out  32  to int_alu data_a_i
//  alu_b_o        out  32  to int_alu data_b_i
//  alu_result_i   in   32  from int_alu data_out_o
//  alu_illegal_i  in   1   from int_alu illegal_inst_o
//  out_valid_o    out  1   result valid to writeback
//  out_ready_i    in   1   writeback accepts result
//  out_result_o   out  32  registered result (0 when illegal)
//  out_rd_o       out  5   destination register of result
//  out_illegal_o  out  1   op was illegal
//  busy_o         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs and operand/result regs 0; cnt 0.
//  States: IDLE, MUL_WAIT, EXEC, RESP.
//  accept = req_valid_i & req_ready_o.
//  req_ready_o = !kill_i & (IDLE | (RESP & out_ready_i)).
//  On accept: latch instr/pc/a/b/rd into operand regs (drive alu_*_o directly).
//   Next state: MUL_WAIT with cnt=MUL_LAT-1 if is_mul & MUL_LAT>1, else EXEC.
//   is_mul: opcode 0110011, funct3 000, funct7 0000001.
//  MUL_WAIT: cnt decrements each cycle; at cnt==1 go EXEC. Operands held stable.
//  EXEC: capture alu_result_i (0 if alu_illegal_i), alu_illegal_i, rd; go RESP.
//  RESP: out_valid_o=1; result/rd/illegal stable until out_ready_i.
//   out_ready_i & !accept -> IDLE; out_ready_i & accept -> new op (back-to-back).
//  Latency accept->out_valid: 2 cycles; MUL: MUL_LAT+1 cycles.
//  Throughput: one op per 2 cycles with out_ready_i held high.
//  out_valid_o is asserted only in RESP.
//  kill_i (any state): next state IDLE; out_valid_o low next cycle; cnt cleared;
//   no accept in kill cycle. A result handshaken in the kill cycle still counts.
//  Operand regs hold their last value in IDLE (no zeroing; saves toggles).
//  Reset asserted mid-op: immediate IDLE and all outputs 0; no partial result.
//  cnt width $clog2(MUL_LAT+1); never underflows (MUL_LAT==1 bypasses MUL_WAIT).
// STRUCTURE
//  Shared package vi_alu_pkg: opcode/funct constants (OP_REG, OP_IMM, OP_LOAD,
//   OP_STORE, OP_BRANCH, OP_JAL, OP_SYSTEM, F7_MUL), state enum, is_mul() func.
//  No sub-module: FSM + counter + regs are flat; int_alu is instantiated by the
//   parent execute stage and wired to alu_*.
// TESTING
//  ADD a=5 b=7 accepted at N -> out_valid at N+2, result 12, rd echoed, illegal 0.
//  MUL a=6 b=7, MUL_LAT=3 -> req_ready 0 N+1..N+3, out_valid N+4, result 42.
//  4 back-to-back ADDIs, out_ready=1 -> results every 2nd cycle, in order.
//  out_ready=0 for 5 cycles in RESP -> result/rd stable, req_ready 0, busy 1.
//  kill_i in MUL_WAIT -> IDLE next cycle, no out_valid; next ADD gives correct sum.
//  opcode 7'h7F -> out_illegal 1, result 0; rsn_i low mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/vi_alu_pkg.sv
// vi_alu_pkg: shared opcode/funct constants, issue FSM states and MUL decode
package vi_alu_pkg;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MUL    = 7'b0000001;
  typedef enum logic [1:0] {IDLE, MUL_WAIT, EXEC, RESP} state_t;
  function automatic logic is_mul(input logic [31:0] instr);
    return instr[6:0] == OP_REG && instr[14:12] == 3'b000 && instr[31:25] == F7_MUL;
  endfunction
endpackage

// File: rtl/int_alu_issue_ctrl_if.sv
// int_alu_issue_ctrl_if: request, ALU and writeback signals of the issue controller
interface int_alu_issue_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_instr_i;
  logic [31:0] req_pc_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [4:0]  req_rd_i;
  logic        kill_i;
  logic [31:0] alu_instr_o;
  logic [31:0] alu_pc_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;
  logic        alu_illegal_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_rd_o;
  logic        out_illegal_o;
  logic        busy_o;
  modport slave (
    input  req_valid_i, req_instr_i, req_pc_i, req_a_i, req_b_i, req_rd_i, kill_i,
           alu_result_i, alu_illegal_i, out_ready_i,
    output req_ready_o, alu_instr_o, alu_pc_o, alu_a_o, alu_b_o,
           out_valid_o, out_result_o, out_rd_o, out_illegal_o, busy_o
  );
  modport master (
    output req_valid_i, req_instr_i, req_pc_i, req_a_i, req_b_i, req_rd_i, kill_i,
           alu_result_i, alu_illegal_i, out_ready_i,
    input  req_ready_o, alu_instr_o, alu_pc_o, alu_a_o, alu_b_o,
           out_valid_o, out_result_o, out_rd_o, out_illegal_o, busy_o
  );
endinterface

// File: rtl/int_alu_issue_ctrl.sv
// int_alu_issue_ctrl: holds operands on the combinational ALU and registers the result for writeback
module int_alu_issue_ctrl
  import vi_alu_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input logic clk_i,
  input logic rsn_i,
  int_alu_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(MUL_LAT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] op_rd;
  logic accept, go_mul;
  // ready is gated by reset so every output reads 0 while rsn_i is low
  assign bus.req_ready_o = rsn_i & !bus.kill_i & (state == IDLE | (state == RESP & bus.out_ready_i));
  assign accept = bus.req_valid_i & bus.req_ready_o;
  assign go_mul = is_mul(bus.req_instr_i) && (MUL_LAT > 1);
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      state             <= IDLE;
      cnt               <= '0;
      op_rd             <= '0;
      bus.alu_instr_o   <= '0;
      bus.alu_pc_o      <= '0;
      bus.alu_a_o       <= '0;
      bus.alu_b_o       <= '0;
      bus.out_valid_o   <= 1'b0;
      bus.out_result_o  <= '0;
      bus.out_rd_o      <= '0;
      bus.out_illegal_o <= 1'b0;
      bus.busy_o        <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_instr_o <= bus.req_instr_i;
        bus.alu_pc_o    <= bus.req_pc_i;
        bus.alu_a_o     <= bus.req_a_i;
        bus.alu_b_o     <= bus.req_b_i;
        op_rd           <= bus.req_rd_i;
        bus.busy_o      <= 1'b1;
        state           <= go_mul ? MUL_WAIT : EXEC;
        cnt             <= go_mul ? CW'(MUL_LAT - 1) : '0;
      end
      if (bus.kill_i) begin
        state           <= IDLE;
        cnt             <= '0;
        bus.out_valid_o <= 1'b0;
        bus.busy_o      <= 1'b0;
      end else
        case (state)
          MUL_WAIT: begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= EXEC;
          end
          EXEC: begin
            bus.out_result_o  <= bus.alu_illegal_i ? '0 : bus.alu_result_i;
            bus.out_illegal_o <= bus.alu_illegal_i;
            bus.out_rd_o      <= op_rd;
            bus.out_valid_o   <= 1'b1;
            state             <= RESP;
          end
          RESP:
            if (bus.out_ready_i) begin
              bus.out_valid_o <= 1'b0;
              if (!accept) begin
                state      <= IDLE;
                bus.busy_o <= 1'b0;
              end
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_int_alu_issue_ctrl.sv
// tb_int_alu_issue_ctrl: directed checks of the issue controller against a small ALU model
module tb_int_alu_issue_ctrl;
  import vi_alu_pkg::*;
  logic clk = 1'b0;
  logic rsn = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int_alu_issue_ctrl_if bus();
  int_alu_issue_ctrl #(.MUL_LAT(3)) dut (.clk_i(clk), .rsn_i(rsn), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.alu_illegal_i = 1'b0;
    bus.alu_result_i  = 32'hDEADBEEF;
    if (bus.alu_instr_o[6:0] == OP_REG && bus.alu_instr_o[14:12] == 3'b000 && bus.alu_instr_o[31:25] == F7_MUL)
      bus.alu_result_i = bus.alu_a_o * bus.alu_b_o;
    else if (bus.alu_instr_o[6:0] == OP_REG && bus.alu_instr_o[14:12] == 3'b000 && bus.alu_instr_o[31:25] == 7'b0)
      bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
    else if (bus.alu_instr_o[6:0] == OP_IMM && bus.alu_instr_o[14:12] == 3'b000)
      bus.alu_result_i = bus.alu_a_o + {{20{bus.alu_instr_o[31]}}, bus.alu_instr_o[31:20]};
    else
      bus.alu_illegal_i = 1'b1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid_i = 1'b1;
    bus.req_instr_i = instr;
    bus.req_pc_i    = 32'h1000 + {27'b0, rd} * 4;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_rd_i    = rd;
  endtask
  function automatic logic [31:0] add_i(input logic [4:0] rd);
    return {7'b0, 5'd2, 5'd1, 3'b000, rd, OP_REG};
  endfunction
  function automatic logic [31:0] mul_i(input logic [4:0] rd);
    return {F7_MUL, 5'd2, 5'd1, 3'b000, rd, OP_REG};
  endfunction
  function automatic logic [31:0] addi_i(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd1, 3'b000, rd, OP_IMM};
  endfunction
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_instr_i = '0;
    bus.req_pc_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_rd_i    = '0;
    bus.kill_i      = 1'b0;
    bus.out_ready_i = 1'b1;
    tick;
    tick;
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_result", bus.out_result_o, 0);
    chk("rst_alu_a", bus.alu_a_o, 0);
    rsn = 1'b1;
    #1;
    chk("idle_ready", bus.req_ready_o, 1);
    drive(add_i(5'd3), 32'd5, 32'd7, 5'd3);
    tick;
    bus.req_valid_i = 1'b0;
    chk("add_n1_valid", bus.out_valid_o, 0);
    chk("add_n1_ready", bus.req_ready_o, 0);
    chk("add_n1_busy", bus.busy_o, 1);
    chk("add_alu_a", bus.alu_a_o, 5);
    chk("add_alu_pc", bus.alu_pc_o, 32'h100C);
    tick;
    chk("add_valid", bus.out_valid_o, 1);
    chk("add_result", bus.out_result_o, 12);
    chk("add_rd", bus.out_rd_o, 3);
    chk("add_illegal", bus.out_illegal_o, 0);
    tick;
    chk("add_done_valid", bus.out_valid_o, 0);
    chk("add_done_busy", bus.busy_o, 0);
    drive(mul_i(5'd5), 32'd6, 32'd7, 5'd5);
    tick;
    bus.req_valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_n%0d_ready", i), bus.req_ready_o, 0);
      chk($sformatf("mul_n%0d_valid", i), bus.out_valid_o, 0);
      tick;
    end
    chk("mul_valid", bus.out_valid_o, 1);
    chk("mul_result", bus.out_result_o, 42);
    chk("mul_rd", bus.out_rd_o, 5);
    tick;
    chk("mul_done_valid", bus.out_valid_o, 0);
    drive(addi_i(12'd1, 5'd10), 32'd0, 32'd0, 5'd10);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b%0d_exec_ready", i), bus.req_ready_o, 0);
      chk($sformatf("b2b%0d_exec_valid", i), bus.out_valid_o, 0);
      tick;
      chk($sformatf("b2b%0d_valid", i), bus.out_valid_o, 1);
      chk($sformatf("b2b%0d_result", i), bus.out_result_o, 32'(11 * i + 1));
      chk($sformatf("b2b%0d_rd", i), bus.out_rd_o, 32'(10 + i));
      if (i < 3) drive(addi_i(12'(i + 2), 5'(11 + i)), 32'(10 * (i + 1)), 32'd0, 5'(11 + i));
      else bus.req_valid_i = 1'b0;
      tick;
    end
    chk("b2b_done_busy", bus.busy_o, 0);
    bus.out_ready_i = 1'b0;
    drive(add_i(5'd9), 32'd100, 32'd23, 5'd9);
    tick;
    drive(add_i(5'd1), 32'd1, 32'd1, 5'd1);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), bus.out_valid_o, 1);
      chk($sformatf("bp%0d_result", i), bus.out_result_o, 123);
      chk($sformatf("bp%0d_rd", i), bus.out_rd_o, 9);
      chk($sformatf("bp%0d_ready", i), bus.req_ready_o, 0);
      chk($sformatf("bp%0d_busy", i), bus.busy_o, 1);
      tick;
    end
    bus.req_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    tick;
    chk("bp_done_valid", bus.out_valid_o, 0);
    chk("bp_done_busy", bus.busy_o, 0);
    drive(32'h0000007F, 32'd1, 32'd2, 5'd7);
    tick;
    bus.req_valid_i = 1'b0;
    tick;
    chk("ill_valid", bus.out_valid_o, 1);
    chk("ill_flag", bus.out_illegal_o, 1);
    chk("ill_result", bus.out_result_o, 0);
    tick;
    bus.kill_i = 1'b1;
    drive(add_i(5'd4), 32'd9, 32'd9, 5'd4);
    #1;
    chk("kill_idle_ready", bus.req_ready_o, 0);
    tick;
    bus.kill_i = 1'b0;
    chk("kill_idle_busy", bus.busy_o, 0);
    drive(mul_i(5'd6), 32'd3, 32'd3, 5'd6);
    tick;
    bus.req_valid_i = 1'b0;
    bus.kill_i = 1'b1;
    tick;
    bus.kill_i = 1'b0;
    chk("kill_busy", bus.busy_o, 0);
    chk("kill_valid", bus.out_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("kill_quiet%0d_valid", i), bus.out_valid_o, 0);
    end
    drive(add_i(5'd8), 32'd1, 32'd2, 5'd8);
    tick;
    bus.req_valid_i = 1'b0;
    tick;
    chk("post_kill_valid", bus.out_valid_o, 1);
    chk("post_kill_result", bus.out_result_o, 3);
    chk("post_kill_rd", bus.out_rd_o, 8);
    tick;
    drive(mul_i(5'd2), 32'd4, 32'd5, 5'd2);
    tick;
    bus.req_valid_i = 1'b0;
    tick;
    rsn = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy_o, 0);
    chk("rst_mid_valid", bus.out_valid_o, 0);
    chk("rst_mid_ready", bus.req_ready_o, 0);
    chk("rst_mid_result", bus.out_result_o, 0);
    chk("rst_mid_rd", bus.out_rd_o, 0);
    chk("rst_mid_alu_a", bus.alu_a_o, 0);
    tick;
    rsn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("rst_after%0d_valid", i), bus.out_valid_o, 0);
    end
    chk("rst_after_ready", bus.req_ready_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
